// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the instruction-memory loader.
// The loader attaches through the slave modport; host and imem sit on the master side.
interface imem_loader_if #(
    parameter int INSTR_WIDTH  = 32,
    parameter int THREAD_WIDTH = 3,
    parameter int ADDR_WIDTH   = 8
);
    logic                    s_valid;
    logic [7:0]              s_data;
    logic                    s_ready;
    logic                    wr_en;
    logic [THREAD_WIDTH-1:0] wr_thread;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [INSTR_WIDTH-1:0]  wr_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  wr_en,
        input  wr_thread,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output wr_en,
        output wr_thread,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Frame-based instruction loader: parses SYNC/THREAD/COUNT/DATA byte frames and
// writes little-endian words into one thread's imem bank, holding the cores meanwhile.
module imem_loader #(
    parameter int INSTR_WIDTH  = 32,
    parameter int THREAD_WIDTH = 3,
    parameter int DEPTH        = 256,
    parameter int ADDR_WIDTH   = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus,
    output logic         hold_core,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int              BYTES      = INSTR_WIDTH / 8;
    localparam int              IDX_W      = $clog2(BYTES);
    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      SYNC       = 8'hA5;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]     MAX_WORDS  = 16'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        THREAD,
        CNT_LO,
        CNT_HI,
        DATA,
        FIN
    } state_t;

    state_t                  state_q;
    logic                    s_ready_q;
    logic                    wr_en_q;
    logic [THREAD_WIDTH-1:0] wr_thread_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [ADDR_WIDTH-1:0]   last_addr_q;
    logic [INSTR_WIDTH-1:0]  wr_data_q;
    logic                    hold_core_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [7:0]              cnt_lo_q;
    logic [IDX_W-1:0]        byte_idx_q;
    logic [TW-1:0]           timer_q;

    logic                    accept;
    logic                    thread_bad;
    logic [15:0]             word_cnt;
    logic [8*(BYTES-1)-1:0]  lanes_flat;

    assign accept     = bus.s_valid & s_ready_q;
    assign thread_bad = (bus.s_data >> THREAD_WIDTH) != 8'd0;
    assign word_cnt   = {bus.s_data, cnt_lo_q};

    // Lower byte lanes of the word being assembled; the top byte goes straight
    // from s_data into wr_data on the last byte of each word.
    generate
        for (genvar gi = 0; gi < BYTES - 1; gi++) begin : g_lane
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_q <= '0;
                end else if (accept && state_q == DATA && byte_idx_q == IDX_W'(gi)) begin
                    lane_q <= bus.s_data;
                end
            end

            assign lanes_flat[8*gi +: 8] = lane_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_ready_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_thread_q <= '0;
            wr_addr_q   <= '0;
            last_addr_q <= '0;
            wr_data_q   <= '0;
            hold_core_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_lo_q    <= '0;
            byte_idx_q  <= '0;
            timer_q     <= '0;
        end else begin
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b1;

            if (wr_en_q) begin
                wr_addr_q <= wr_addr_q + 1'b1;
            end
            // A SYNC accepted in an err cycle re-asserts hold below, so the set wins.
            if (done_q || err_q) begin
                hold_core_q <= 1'b0;
            end
            if (accept) begin
                timer_q <= '0;
            end

            unique case (state_q)
                IDLE: begin
                    if (accept && bus.s_data == SYNC) begin
                        state_q     <= THREAD;
                        busy_q      <= 1'b1;
                        hold_core_q <= 1'b1;
                    end
                end
                THREAD: begin
                    if (accept) begin
                        if (thread_bad) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            wr_thread_q <= bus.s_data[THREAD_WIDTH-1:0];
                            state_q     <= CNT_LO;
                        end
                    end
                end
                CNT_LO: begin
                    if (accept) begin
                        cnt_lo_q <= bus.s_data;
                        state_q  <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (accept) begin
                        if (word_cnt == 16'd0 || word_cnt > MAX_WORDS) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            last_addr_q <= ADDR_WIDTH'(word_cnt - 16'd1);
                            wr_addr_q   <= '0;
                            byte_idx_q  <= '0;
                            state_q     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (byte_idx_q == IDX_LAST) begin
                            byte_idx_q <= '0;
                            wr_en_q    <= 1'b1;
                            wr_data_q  <= {bus.s_data, lanes_flat};
                            // wr_addr has already advanced past the previous word here
                            if (wr_addr_q == last_addr_q) begin
                                state_q   <= FIN;
                                s_ready_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // An accepted byte always beats expiry, so only idle cycles age the frame.
            if (busy_q && state_q != FIN && !accept) begin
                if (timer_q == TIMER_LAST) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_thread = wr_thread_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign hold_core     = hold_core_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule
